irq_timer: RTL and testbench
============================

# irq_timer

Memory-mapped 32-bit reload timer and interrupt sequencer for the MIPS single-cycle datapath. It sits directly upstream of the control unit. It owns the timer registers TH, TL and TCON on the data-memory bus, latches overflow events and produces the single-cycle `BeginInterrupt` pulse that the control unit consumes to redirect the PC to the exception vector. It holds off further requests until the processor leaves kernel mode.

## Interface
Parameters:
- `BASE_ADDR`, 32'h4000_0000, base of the 16-byte register window; `Addr[31:4]` must match `BASE_ADDR[31:4]`.
- `PRESCALE`, 4, clock cycles per TL tick when prescaling is compiled in (see Configuration); legal range 1..65535.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Addr`  in  32  data-bus byte address.
- `WriteData`  in  32  data-bus write data.
- `MemWrite`  in  1  bus write strobe.
- `MemRead`  in  1  bus read strobe.
- `KernelMode`  in  1  PC[31] of the current instruction; 1 = handler or kernel code running.
- `ReadData`  out  32  combinational read data.
- `BeginInterrupt`  out  1  registered one-cycle interrupt request to the control unit.

## Operation
Register map (`Addr[3:2]`):
- 0 = TH, the reload value, read/write.
- 1 = TL, the counter, read/write.
- 2 = TCON, read/write:
  - bit0 = timer enable.
  - bit1 = interrupt enable.
  - bit2 = status (pending).
  - bits[31:3] read 0; writes to them are ignored.
- 3 = reserved; reads 0, writes ignored.

Counting:
- When TCON[0]=1 and a tick occurs, TL <= TL+1, except when TL == 32'hFFFF_FFFF.
- In that case TL <= TH. If TCON[1]=1, TCON[2] <= 1.

Bus writes:
- A write is accepted when `MemWrite` is high and the address matches the window.
- A software write to TL overrides a tick in the same cycle.
- A TCON write sets bits[2:0] from `WriteData[2:0]`. Software clears status by writing bit2=0.
- If an overflow coincides with a TCON write of bit2=0, status ends at 1. Interrupts are never lost.

Bus reads:
- `ReadData` = selected register when `MemRead` is high and the address matches.
- Otherwise `ReadData` = 32'h0.

Sequencer FSM states: IDLE, FIRE, SERVICE.
- IDLE -> FIRE when TCON[2] & TCON[1] & ~KernelMode.
- FIRE -> SERVICE unconditionally.
- SERVICE -> IDLE when KernelMode == 0.
- `BeginInterrupt` = 1 only in FIRE.

Pending behaviour:
- Overflows during FIRE or SERVICE still set status, but do not fire until the FSM is back in IDLE.
- If the handler exits without clearing status, a new request fires 2 cycles after KernelMode falls.

## Timing
- Reset values: TH=0, TL=0, TCON=0, prescale counter=0, FSM=IDLE, `BeginInterrupt`=0.
- Reset is asynchronous: asserting it during FIRE drops `BeginInterrupt` immediately.
- `ReadData` is combinational, with zero latency.
- Register writes take effect at the same rising edge.
- Overflow latency:
  - Edge E0: TL wraps and status is set.
  - Edge E1: FSM enters FIRE, so `BeginInterrupt` is high from E1 to E2.
  - Edge E2: FSM enters SERVICE.
- `BeginInterrupt` is never high for 2 consecutive cycles.
- Minimum spacing between two pulses is 3 cycles.
- TL wrap is always to TH, never to 0, unless TH = 0.

## Configuration
- `IRQ_TIMER_PRESCALER_EN` defined:
  - A 16-bit prescale counter counts 0..PRESCALE-1.
  - A tick occurs on the cycle the counter equals PRESCALE-1, after which the counter returns to 0.
  - The counter runs only while TCON[0]=1 and holds its value otherwise.
  - A write to TL resets it to 0.
- `IRQ_TIMER_PRESCALER_EN` undefined:
  - Every cycle with TCON[0]=1 is a tick.
  - No prescale counter exists.
  - `PRESCALE` is ignored.

## Test plan
- Reset check: assert `reset` mid-cycle -> all registers read 0 and `BeginInterrupt`=0 immediately. After release, a read of TCON returns 32'h0.
- Overflow and pulse (no prescale):
  - Stimulus: TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3, KernelMode=0.
  - Required response: TL reads FFFF_FFFF, then FFFF_FFF0 on the next edge. TCON reads 7.
  - `BeginInterrupt` is high for exactly 1 cycle, 1 edge after the wrap.
- Hold-off:
  - Stimulus: hold KernelMode=1 for 20 cycles after the pulse while 2 more overflows occur (TH=FFFF_FFF8).
  - Required response: no further pulse. Dropping KernelMode gives exactly one pulse 2 cycles later.
- Clear race: a TCON write of 32'h3 in the same cycle as an overflow -> TCON reads 7 afterwards.
- Write priority: a TL write of 32'h1234 in a counting cycle -> TL reads 32'h1234, not 32'h1235. An unmapped address 0x4000000C reads 0.
- Prescale (with macro, PRESCALE=4):
  - TL advances by 1 every 4 cycles: TL=0 -> 3 after 12 cycles.
  - Clearing TCON[0] freezes both TL and the prescale counter.

Source files
------------

// File: rtl/irq_timer.sv
// irq_timer: TH/TL/TCON reload timer plus interrupt sequencer for the
// MIPS single-cycle datapath.
// Ports: clk, reset (async, active-high); bus Addr/WriteData/MemWrite/
// MemRead -> ReadData (combinational); KernelMode in; BeginInterrupt out
// (registered single-cycle request to the control unit).
// Optional build macro: IRQ_TIMER_PRESCALER_EN (PRESCALE clocks per tick).
module irq_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        KernelMode,
  output logic [31:0] ReadData,
  output logic        BeginInterrupt
);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    SERVICE
  } state_t;

  state_t state, stateNext;

  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic        hit;
  logic        selTh, selTl, selTcon;
  logic        wrTh, wrTl, wrTcon;
  logic        tick, ovf, setStatus;
  logic        unusedAddr;

  if (PRESCALE < 1 || PRESCALE > 65535) begin : gBadPrescale
    $error("irq_timer: PRESCALE out of range");
  end

  assign unusedAddr = ^Addr[1:0];

  assign hit     = Addr[31:4] == BASE_ADDR[31:4];
  assign selTh   = hit && (Addr[3:2] == 2'd0);
  assign selTl   = hit && (Addr[3:2] == 2'd1);
  assign selTcon = hit && (Addr[3:2] == 2'd2);

  assign wrTh   = MemWrite && selTh;
  assign wrTl   = MemWrite && selTl;
  assign wrTcon = MemWrite && selTcon;

`ifdef IRQ_TIMER_PRESCALER_EN
  localparam logic [15:0] PreMax = 16'(PRESCALE - 1);

  logic [15:0] preCnt;

  assign tick = tcon[0] && (preCnt == PreMax);

  // Counter freezes with the timer disabled; a TL write restarts the period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preCnt <= '0;
    end else if (wrTl) begin
      preCnt <= '0;
    end else if (tcon[0]) begin
      preCnt <= tick ? '0 : preCnt + 16'd1;
    end
  end
`else
  assign tick = tcon[0];
`endif

  // A software TL write swallows the tick, so it cannot raise an overflow.
  assign ovf       = tick && !wrTl && (tl == 32'hFFFF_FFFF);
  assign setStatus = ovf && tcon[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wrTh) th <= WriteData;
      if (wrTl) begin
        tl <= WriteData;
      end else if (ovf) begin
        tl <= th;
      end else if (tick) begin
        tl <= tl + 32'd1;
      end
      // An overflow in the same cycle as a status clear wins.
      if (wrTcon) begin
        tcon <= {WriteData[2] | setStatus, WriteData[1:0]};
      end else if (setStatus) begin
        tcon[2] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (tcon[2] && tcon[1] && !KernelMode) stateNext = FIRE;
      FIRE:    stateNext = SERVICE;
      SERVICE: if (!KernelMode) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign BeginInterrupt = (state == FIRE);

  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      unique case (1'b1)
        selTh:   ReadData = th;
        selTl:   ReadData = tl;
        selTcon: ReadData = {29'd0, tcon};
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer.sv
// tb_irq_timer: vector table, directed corner sequences and a random run
// against a behavioural model of irq_timer.
module tb_irq_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          PRE  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        KernelMode;
  logic [31:0] ReadData;
  logic        BeginInterrupt;

  int errors = 0;
  int checks = 0;

  irq_timer #(
    .BASE_ADDR(BASE),
    .PRESCALE (PRE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Addr          (Addr),
    .WriteData     (WriteData),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .KernelMode    (KernelMode),
    .ReadData      (ReadData),
    .BeginInterrupt(BeginInterrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  off;
    logic [31:0] wd;
    logic        km;
    logic [31:0] expRd;
    logic        expIrq;
  } vec_t;

  vec_t vec[13];

  // behavioural model state
  logic [31:0] mTh, mTl;
  logic [2:0]  mCon;
  bit          mIrq, mBusy;
`ifdef IRQ_TIMER_PRESCALER_EN
  int          mPre;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    Addr      = BASE | {28'h0, off};
    WriteData = d;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic rdChk(input string nm, input logic [3:0] off,
                       input logic [31:0] exp);
    Addr     = BASE | {28'h0, off};
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    #1;
    chk(nm, ReadData, exp);
    MemRead = 1'b0;
  endtask

  task automatic doReset();
    reset      = 1'b1;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    KernelMode = 1'b0;
    Addr       = BASE;
    WriteData  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic got;
    logic [31:0] expRd, nTh, nTl;
    logic [2:0] nCon;
    bit tick, ovf, wrHit, nIrq, nBusy, prevIrq;
    logic [1:0] sel;

    doReset();

`ifndef IRQ_TIMER_PRESCALER_EN
    //         we    re    off   wd             km    expRd          irq
    vec[0]  = '{1'b0, 1'b1, 4'h8, 32'h0,         1'b0, 32'h0,         1'b0};
    vec[1]  = '{1'b0, 1'b1, 4'h4, 32'h0,         1'b0, 32'h0,         1'b0};
    vec[2]  = '{1'b1, 1'b0, 4'h0, 32'hFFFF_FFF0, 1'b0, 32'h0,         1'b0};
    vec[3]  = '{1'b1, 1'b0, 4'h4, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0};
    vec[4]  = '{1'b1, 1'b0, 4'h8, 32'h3,         1'b0, 32'h0,         1'b0};
    vec[5]  = '{1'b0, 1'b1, 4'h4, 32'h0,         1'b0, 32'hFFFF_FFFE, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 4'h4, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0};
    vec[7]  = '{1'b0, 1'b1, 4'h4, 32'h0,         1'b0, 32'hFFFF_FFF0, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 4'h8, 32'h0,         1'b1, 32'h7,         1'b1};
    vec[9]  = '{1'b0, 1'b1, 4'h4, 32'h0,         1'b1, 32'hFFFF_FFF2, 1'b0};
    vec[10] = '{1'b1, 1'b0, 4'h8, 32'h3,         1'b1, 32'h0,         1'b0};
    vec[11] = '{1'b0, 1'b1, 4'h8, 32'h0,         1'b0, 32'h3,         1'b0};
    vec[12] = '{1'b0, 1'b1, 4'h4, 32'h0,         1'b0, 32'hFFFF_FFF5, 1'b0};

    for (int i = 0; i < 13; i++) begin
      MemWrite   = vec[i].we;
      MemRead    = vec[i].re;
      Addr       = BASE | {28'h0, vec[i].off};
      WriteData  = vec[i].wd;
      KernelMode = vec[i].km;
      #1;
      chk($sformatf("vec%0d rd", i), ReadData, vec[i].expRd);
      chk($sformatf("vec%0d irq", i), {31'h0, BeginInterrupt},
          {31'h0, vec[i].expIrq});
      @(posedge clk);
      #1;
    end
    MemWrite = 1'b0;
    MemRead  = 1'b0;

    // hold-off while the handler runs
    wr(4'h8, 32'h0);
    wr(4'h8, 32'h0);
    wr(4'h0, 32'hFFFF_FFF8);
    wr(4'h4, 32'hFFFF_FFFF);
    wr(4'h8, 32'h3);
    chk("hold pre", {31'h0, BeginInterrupt}, 32'h0);
    idle();
    chk("hold E0", {31'h0, BeginInterrupt}, 32'h0);
    idle();
    chk("hold E1", {31'h0, BeginInterrupt}, 32'h1);
    KernelMode = 1'b1;
    idle();
    chk("hold E2", {31'h0, BeginInterrupt}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (BeginInterrupt) pulses++;
    end
    chk("hold pulses", pulses, 0);
    KernelMode = 1'b0;
    idle();
    chk("exit +1", {31'h0, BeginInterrupt}, 32'h0);
    idle();
    chk("exit +2", {31'h0, BeginInterrupt}, 32'h1);
    KernelMode = 1'b1;
    idle();
    chk("exit +3", {31'h0, BeginInterrupt}, 32'h0);

    // status clear racing an overflow
    wr(4'h8, 32'h0);
    wr(4'h8, 32'h0);
    wr(4'h4, 32'hFFFF_FFFE);
    wr(4'h8, 32'h3);
    idle();
    wr(4'h8, 32'h3);
    rdChk("clear race", 4'h8, 32'h7);
    rdChk("race wrap", 4'h4, 32'hFFFF_FFF8);
    idle();
`endif

    // write priority, decode and masking
    KernelMode = 1'b1;
    wr(4'h8, 32'h1);
    wr(4'h4, 32'h1234);
    rdChk("tl write prio", 4'h4, 32'h1234);
    rdChk("reserved rd", 4'hC, 32'h0);
    idle();
    wr(4'h0, 32'hA5A5_0000);
    rdChk("th rd", 4'h0, 32'hA5A5_0000);
    Addr = BASE | 32'h4;
    #1;
    chk("no memread", ReadData, 32'h0);
    idle();
    Addr    = BASE + 32'h10;
    MemRead = 1'b1;
    #1;
    chk("out of window", ReadData, 32'h0);
    wr(4'h8, 32'hFFFF_FFF9);
    rdChk("tcon mask", 4'h8, 32'h1);
    idle();

    // asynchronous reset while firing
    KernelMode = 1'b0;
    wr(4'h0, 32'h0);
    wr(4'h8, 32'h0);
    wr(4'h4, 32'hFFFF_FFFF);
    wr(4'h8, 32'h3);
    for (int i = 0; i < 40; i++) begin
      if (BeginInterrupt) break;
      idle();
    end
    got = BeginInterrupt;
    chk("reach fire", {31'h0, got}, 32'h1);
    Addr    = BASE | 32'h8;
    MemRead = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("rst irq", {31'h0, BeginInterrupt}, 32'h0);
    chk("rst tcon", ReadData, 32'h0);
    @(negedge clk);
    reset   = 1'b0;
    MemRead = 1'b0;
    @(posedge clk);
    #1;
    rdChk("post rst tcon", 4'h8, 32'h0);
    chk("post rst irq", {31'h0, BeginInterrupt}, 32'h0);
    idle();

`ifdef IRQ_TIMER_PRESCALER_EN
    wr(4'h8, 32'h1);
    repeat (12) idle();
    rdChk("pre 12cyc", 4'h4, 32'h3);
    wr(4'h8, 32'h0);
    repeat (10) idle();
    rdChk("pre frozen", 4'h4, 32'h3);
    wr(4'h8, 32'h1);
    repeat (2) idle();
    rdChk("pre resume2", 4'h4, 32'h3);
    idle();
    rdChk("pre resume3", 4'h4, 32'h4);
`endif

    // randomized run against the model
    doReset();
    mTh   = '0;
    mTl   = '0;
    mCon  = '0;
    mIrq  = 1'b0;
    mBusy = 1'b0;
`ifdef IRQ_TIMER_PRESCALER_EN
    mPre  = 0;
`endif
    prevIrq = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      sel = 2'($urandom_range(0, 3));
      MemWrite = ($urandom_range(0, 99) < 25);
      MemRead  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) Addr = BASE + 32'h10;
      else Addr = BASE | {28'h0, sel, 2'b00};
      WriteData = $urandom;
      if (sel == 2'd1 && $urandom_range(0, 3) != 0)
        WriteData = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (sel == 2'd0 && $urandom_range(0, 1) != 0)
        WriteData = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (sel == 2'd2 && $urandom_range(0, 7) != 0) WriteData[0] = 1'b1;
      if ($urandom_range(0, 5) == 0) KernelMode = ~KernelMode;
      #1;

      expRd = 32'h0;
      if (MemRead && Addr[31:4] == BASE[31:4]) begin
        case (Addr[3:2])
          2'd0:    expRd = mTh;
          2'd1:    expRd = mTl;
          2'd2:    expRd = {29'h0, mCon};
          default: expRd = 32'h0;
        endcase
      end
      chk("rand rd", ReadData, expRd);
      chk("rand irq", {31'h0, BeginInterrupt}, {31'h0, mIrq});
      chk("rand no double", {31'h0, BeginInterrupt & prevIrq}, 32'h0);
      prevIrq = BeginInterrupt;

      wrHit = MemWrite && (Addr[31:4] == BASE[31:4]);
`ifdef IRQ_TIMER_PRESCALER_EN
      tick = mCon[0] && (mPre == PRE - 1);
`else
      tick = mCon[0];
`endif
      ovf = tick && !(wrHit && Addr[3:2] == 2'd1) && (mTl == 32'hFFFF_FFFF);
      nTh = (wrHit && Addr[3:2] == 2'd0) ? WriteData : mTh;
      if (wrHit && Addr[3:2] == 2'd1) nTl = WriteData;
      else if (ovf) nTl = mTh;
      else if (tick) nTl = mTl + 32'd1;
      else nTl = mTl;
      nCon = (wrHit && Addr[3:2] == 2'd2) ? WriteData[2:0] : mCon;
      if (ovf && mCon[1]) nCon[2] = 1'b1;
      // a request fires from rest; the handler occupies the sequencer
      // from the pulse until the first edge seen outside kernel mode
      nIrq  = !mIrq && !mBusy && mCon[2] && mCon[1] && !KernelMode;
      nBusy = mIrq || (mBusy && KernelMode);

      @(posedge clk);
      #1;
`ifdef IRQ_TIMER_PRESCALER_EN
      if (wrHit && Addr[3:2] == 2'd1) mPre = 0;
      else if (mCon[0]) mPre = (mPre + 1) % PRE;
`endif
      mTh   = nTh;
      mTl   = nTl;
      mCon  = nCon;
      mIrq  = nIrq;
      mBusy = nBusy;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
